axi_cpl_tlp_builder: RTL and testbench

//  Downstream of the AXI read controller in the PCIe-to-AXI-Lite bridge: records the PCIe

---
 rtl/pcie_bridge_pkg.sv | 48 ++++
 rtl/cpl_ctx_fifo.sv | 74 +++++++
 rtl/axi_cpl_tlp_builder.sv | 144 ++++++++++++++
 tb/tb_axi_cpl_tlp_builder.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pcie_bridge_pkg.sv
// Shared types and helpers for the PCIe-to-AXI-Lite bridge.
//   cpl_ctx_t           : PCIe context captured for each outstanding read
//   be_to_byte_count()  : single-DW completion byte count from first-DW byte enables
//   be_to_lower_offset(): byte offset of the lowest enabled byte
//   CPL_STATUS_SC       : successful-completion status code, used by the formatter
package pcie_bridge_pkg;

    localparam logic [2:0] CPL_STATUS_SC = 3'b000;

    typedef struct packed {
        logic [15:0] requester_id;
        logic [7:0]  tag;
        logic [2:0]  tc;
        logic [1:0]  attr;
        logic [6:0]  address;
        logic [3:0]  byte_enable;
    } cpl_ctx_t;

    // Span from lowest to highest enabled byte; an empty mask still reports 1 byte.
    function automatic logic [11:0] be_to_byte_count(input logic [3:0] be);
        logic [11:0] bc;
        if (be[3] && be[0])
            bc = 12'd4;
        else if ((be[3:2] == 2'b01 && be[0]) || (be[3] && be[1:0] == 2'b10))
            bc = 12'd3;
        else if (be == 4'b0011 || be == 4'b0110 || be == 4'b1100)
            bc = 12'd2;
        else
            bc = 12'd1;
        return bc;
    endfunction

    function automatic logic [1:0] be_to_lower_offset(input logic [3:0] be);
        logic [1:0] off;
        if (be[0])
            off = 2'd0;
        else if (be[1])
            off = 2'd1;
        else if (be[2])
            off = 2'd2;
        else if (be[3])
            off = 2'd3;
        else
            off = 2'd0;
        return off;
    endfunction

endpackage

// File: rtl/cpl_ctx_fifo.sv
// Synchronous FIFO of read-request contexts.
//   clk, rst   : clock, asynchronous active-high reset
//   push_req   : write request; accepted when not full, or when full and popping
//   push_ctx   : context to store
//   pop_req    : remove head (ignored while empty)
//   head_ctx   : current head entry
//   empty/full : occupancy flags
//   count      : number of stored entries
// Depth need not be a power of two: pointers wrap explicitly at DEPTH-1.
module cpl_ctx_fifo
    import pcie_bridge_pkg::*;
#(
    parameter int DEPTH = 5
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           push_req,
    input  cpl_ctx_t                       push_ctx,
    input  logic                           pop_req,
    output cpl_ctx_t                       head_ctx,
    output logic                           empty,
    output logic                           full,
    output logic [$clog2(DEPTH+1)-1:0]     count
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);

    cpl_ctx_t           mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               push_ok, pop_ok;

    assign empty    = (count_q == '0);
    assign full     = (count_q == CNT_W'(DEPTH));
    assign count    = count_q;
    assign head_ctx = mem_q[rd_ptr_q];

    always_comb begin
        pop_ok   = pop_req && !empty;
        push_ok  = push_req && (!full || pop_ok);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok)
            wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        if (pop_ok)
            rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        if (push_ok && !pop_ok)
            count_d = count_q + 1'b1;
        else if (pop_ok && !push_ok)
            count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is data only; validity is tracked solely by the pointers and count.
    always_ff @(posedge clk) begin
        if (push_ok)
            mem_q[wr_ptr_q] <= push_ctx;
    end

endmodule

// File: rtl/axi_cpl_tlp_builder.sv
// Pairs in-order AXI read beats with stored PCIe request contexts and presents
// single-DW completion descriptors to the completion TLP formatter.
//   m_axi_aclk/m_axi_areset : clock, asynchronous active-high reset
//   req_*                   : accepted read request context (push)
//   req_track_full          : context FIFO full with no pop this cycle
//   axi_cpld_*              : returning read data beats
//   cpl_*                   : registered completion descriptor and data
//   outstanding_cnt         : contexts currently stored
//   err_overflow/err_orphan : sticky error flags
module axi_cpl_tlp_builder
    import pcie_bridge_pkg::*;
#(
    parameter int OUTSTANDING_READS = 5,
    parameter int TCQ               = 1
) (
    input  logic                                     m_axi_aclk,
    input  logic                                     m_axi_areset,
    input  logic                                     req_valid,
    input  logic [15:0]                              req_requester_id,
    input  logic [7:0]                               req_tag,
    input  logic [2:0]                               req_tc,
    input  logic [1:0]                               req_attr,
    input  logic [6:0]                               req_address,
    input  logic [3:0]                               req_byte_enable,
    output logic                                     req_track_full,
    input  logic                                     axi_cpld_valid,
    output logic                                     axi_cpld_ready,
    input  logic [31:0]                              axi_cpld_data,
    output logic                                     cpl_valid,
    input  logic                                     cpl_ready,
    output logic [15:0]                              cpl_requester_id,
    output logic [7:0]                               cpl_tag,
    output logic [2:0]                               cpl_tc,
    output logic [1:0]                               cpl_attr,
    output logic [6:0]                               cpl_lower_addr,
    output logic [11:0]                              cpl_byte_count,
    output logic [31:0]                              cpl_data,
    output logic [$clog2(OUTSTANDING_READS+1)-1:0]   outstanding_cnt,
    output logic                                     err_overflow,
    output logic                                     err_orphan
);

    cpl_ctx_t    req_ctx, head_ctx;
    logic        fifo_empty, fifo_full;
    logic        beat_accept, pop;

    logic        cpl_valid_q, cpl_valid_d;
    logic [15:0] rid_q, rid_d;
    logic [7:0]  tag_q, tag_d;
    logic [2:0]  tc_q, tc_d;
    logic [1:0]  attr_q, attr_d;
    logic [6:0]  laddr_q, laddr_d;
    logic [11:0] bc_q, bc_d;
    logic [31:0] data_q, data_d;
    logic        ovf_q, ovf_d;
    logic        orph_q, orph_d;

    assign req_ctx = '{requester_id: req_requester_id, tag: req_tag, tc: req_tc,
                       attr: req_attr, address: req_address, byte_enable: req_byte_enable};

    // The output slot is free when empty or being drained this cycle.
    assign axi_cpld_ready = !cpl_valid_q || cpl_ready;
    assign beat_accept    = axi_cpld_valid && axi_cpld_ready;
    // A context pushed this cycle is not yet visible, so a beat on an empty FIFO is orphaned.
    assign pop            = beat_accept && !fifo_empty;
    assign req_track_full = fifo_full && !pop;

    cpl_ctx_fifo #(
        .DEPTH    (OUTSTANDING_READS)
    ) u_ctx_fifo (
        .clk      (m_axi_aclk),
        .rst      (m_axi_areset),
        .push_req (req_valid),
        .push_ctx (req_ctx),
        .pop_req  (pop),
        .head_ctx (head_ctx),
        .empty    (fifo_empty),
        .full     (fifo_full),
        .count    (outstanding_cnt)
    );

    always_comb begin
        cpl_valid_d = cpl_valid_q;
        rid_d       = rid_q;
        tag_d       = tag_q;
        tc_d        = tc_q;
        attr_d      = attr_q;
        laddr_d     = laddr_q;
        bc_d        = bc_q;
        data_d      = data_q;
        ovf_d       = ovf_q || (req_valid && req_track_full);
        orph_d      = orph_q || (beat_accept && fifo_empty);
        if (pop) begin
            cpl_valid_d = 1'b1;
            rid_d       = head_ctx.requester_id;
            tag_d       = head_ctx.tag;
            tc_d        = head_ctx.tc;
            attr_d      = head_ctx.attr;
            laddr_d     = {head_ctx.address[6:2], be_to_lower_offset(head_ctx.byte_enable)};
            bc_d        = be_to_byte_count(head_ctx.byte_enable);
            data_d      = axi_cpld_data;
        end else if (cpl_ready) begin
            cpl_valid_d = 1'b0;
        end
    end

    always_ff @(posedge m_axi_aclk or posedge m_axi_areset) begin
        if (m_axi_areset) begin
            cpl_valid_q <= 1'b0;
            rid_q       <= '0;
            tag_q       <= '0;
            tc_q        <= '0;
            attr_q      <= '0;
            laddr_q     <= '0;
            bc_q        <= '0;
            data_q      <= '0;
            ovf_q       <= 1'b0;
            orph_q      <= 1'b0;
        end else begin
            cpl_valid_q <= cpl_valid_d;
            rid_q       <= rid_d;
            tag_q       <= tag_d;
            tc_q        <= tc_d;
            attr_q      <= attr_d;
            laddr_q     <= laddr_d;
            bc_q        <= bc_d;
            data_q      <= data_d;
            ovf_q       <= ovf_d;
            orph_q      <= orph_d;
        end
    end

    assign cpl_valid        = cpl_valid_q;
    assign cpl_requester_id = rid_q;
    assign cpl_tag          = tag_q;
    assign cpl_tc           = tc_q;
    assign cpl_attr         = attr_q;
    assign cpl_lower_addr   = laddr_q;
    assign cpl_byte_count   = bc_q;
    assign cpl_data         = data_q;
    assign err_overflow     = ovf_q;
    assign err_orphan       = orph_q;

endmodule

// File: tb/tb_axi_cpl_tlp_builder.sv
module tb_axi_cpl_tlp_builder;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic [15:0] req_requester_id;
    logic [7:0]  req_tag;
    logic [2:0]  req_tc;
    logic [1:0]  req_attr;
    logic [6:0]  req_address;
    logic [3:0]  req_byte_enable;
    logic        req_track_full;
    logic        axi_cpld_valid;
    logic        axi_cpld_ready;
    logic [31:0] axi_cpld_data;
    logic        cpl_valid;
    logic        cpl_ready;
    logic [15:0] cpl_requester_id;
    logic [7:0]  cpl_tag;
    logic [2:0]  cpl_tc;
    logic [1:0]  cpl_attr;
    logic [6:0]  cpl_lower_addr;
    logic [11:0] cpl_byte_count;
    logic [31:0] cpl_data;
    logic [3:0]  outstanding_cnt;
    logic        err_overflow;
    logic        err_orphan;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    axi_cpl_tlp_builder #(.OUTSTANDING_READS(5), .TCQ(1)) dut (
        .m_axi_aclk       (clk),
        .m_axi_areset     (rst),
        .req_valid        (req_valid),
        .req_requester_id (req_requester_id),
        .req_tag          (req_tag),
        .req_tc           (req_tc),
        .req_attr         (req_attr),
        .req_address      (req_address),
        .req_byte_enable  (req_byte_enable),
        .req_track_full   (req_track_full),
        .axi_cpld_valid   (axi_cpld_valid),
        .axi_cpld_ready   (axi_cpld_ready),
        .axi_cpld_data    (axi_cpld_data),
        .cpl_valid        (cpl_valid),
        .cpl_ready        (cpl_ready),
        .cpl_requester_id (cpl_requester_id),
        .cpl_tag          (cpl_tag),
        .cpl_tc           (cpl_tc),
        .cpl_attr         (cpl_attr),
        .cpl_lower_addr   (cpl_lower_addr),
        .cpl_byte_count   (cpl_byte_count),
        .cpl_data         (cpl_data),
        .outstanding_cnt  (outstanding_cnt),
        .err_overflow     (err_overflow),
        .err_orphan       (err_orphan)
    );

    typedef struct {
        logic [3:0]  be;
        logic [6:0]  addr;
        logic [7:0]  tag;
        logic [31:0] data;
        logic [6:0]  exp_laddr;
        logic [11:0] exp_bc;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_req(input logic [7:0] tag, input logic [3:0] be, input logic [6:0] addr);
        req_valid        = 1'b1;
        req_tag          = tag;
        req_byte_enable  = be;
        req_address      = addr;
        req_requester_id = {8'hA5, tag};
        req_tc           = tag[2:0];
        req_attr         = tag[1:0];
    endtask

    task automatic push(input logic [7:0] tag, input logic [3:0] be, input logic [6:0] addr);
        set_req(tag, be, addr);
        tick();
        req_valid = 1'b0;
    endtask

    task automatic beat(input logic [31:0] data);
        axi_cpld_valid = 1'b1;
        axi_cpld_data  = data;
        tick();
        axi_cpld_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, ".cpl_valid"},  {31'd0, cpl_valid}, 32'd0);
        check({tag, ".cpld_ready"}, {31'd0, axi_cpld_ready}, 32'd1);
        check({tag, ".track_full"}, {31'd0, req_track_full}, 32'd0);
        check({tag, ".cnt"},        {28'd0, outstanding_cnt}, 32'd0);
        check({tag, ".errs"},       {30'd0, err_overflow, err_orphan}, 32'd0);
        check({tag, ".fields"},     {cpl_tag, cpl_byte_count, 5'd0, cpl_lower_addr}, 32'd0);
        check({tag, ".data"},       cpl_data, 32'd0);
    endtask

    initial begin
        vecs[0] = '{4'b0110, 7'h08, 8'h30, 32'h0000_0001, 7'h09, 12'd2};
        vecs[1] = '{4'b1000, 7'h08, 8'h31, 32'h1111_2222, 7'h0B, 12'd1};
        vecs[2] = '{4'b0000, 7'h08, 8'h32, 32'h3333_4444, 7'h08, 12'd1};
        vecs[3] = '{4'b0111, 7'h08, 8'h33, 32'h5555_6666, 7'h08, 12'd3};
        vecs[4] = '{4'b1001, 7'h7F, 8'h34, 32'h7777_8888, 7'h7C, 12'd4};
        vecs[5] = '{4'b0101, 7'h10, 8'h35, 32'h9999_AAAA, 7'h10, 12'd3};
        vecs[6] = '{4'b1010, 7'h22, 8'h36, 32'hBBBB_CCCC, 7'h21, 12'd3};
        vecs[7] = '{4'b1100, 7'h00, 8'h37, 32'hDDDD_EEEE, 7'h02, 12'd2};
        vecs[8] = '{4'b0011, 7'h45, 8'h38, 32'hFFFF_0000, 7'h44, 12'd2};
        vecs[9] = '{4'b0100, 7'h04, 8'h39, 32'h1234_5678, 7'h06, 12'd1};

        rst = 1'b1;
        req_valid = 1'b0; req_requester_id = '0; req_tag = '0; req_tc = '0;
        req_attr = '0; req_address = '0; req_byte_enable = '0;
        axi_cpld_valid = 1'b0; axi_cpld_data = '0; cpl_ready = 1'b0;
        tick();
        tick();
        check_reset_state("reset");
        rst = 1'b0;
        tick();

        // Basic single read
        push(8'h12, 4'b1111, 7'h44);
        check("t1.cnt_after_push", {28'd0, outstanding_cnt}, 32'd1);
        beat(32'hDEADBEEF);
        check("t1.cpl_valid", {31'd0, cpl_valid}, 32'd1);
        check("t1.tag",       {24'd0, cpl_tag}, 32'h12);
        check("t1.rid",       {16'd0, cpl_requester_id}, 32'hA512);
        check("t1.laddr",     {25'd0, cpl_lower_addr}, 32'h44);
        check("t1.bc",        {20'd0, cpl_byte_count}, 32'd4);
        check("t1.data",      cpl_data, 32'hDEADBEEF);
        check("t1.cnt",       {28'd0, outstanding_cnt}, 32'd0);
        cpl_ready = 1'b1;
        tick();
        check("t1.cpl_drop", {31'd0, cpl_valid}, 32'd0);
        cpl_ready = 1'b0;

        // Byte-enable table
        for (int i = 0; i < 10; i++) begin
            push(vecs[i].tag, vecs[i].be, vecs[i].addr);
            beat(vecs[i].data);
            check($sformatf("be%0d.valid", i), {31'd0, cpl_valid}, 32'd1);
            check($sformatf("be%0d.tag", i),   {24'd0, cpl_tag}, {24'd0, vecs[i].tag});
            check($sformatf("be%0d.tc_attr", i), {27'd0, cpl_tc, cpl_attr},
                  {27'd0, vecs[i].tag[2:0], vecs[i].tag[1:0]});
            check($sformatf("be%0d.laddr", i), {25'd0, cpl_lower_addr}, {25'd0, vecs[i].exp_laddr});
            check($sformatf("be%0d.bc", i),    {20'd0, cpl_byte_count}, {20'd0, vecs[i].exp_bc});
            check($sformatf("be%0d.data", i),  cpl_data, vecs[i].data);
            cpl_ready = 1'b1;
            tick();
            cpl_ready = 1'b0;
        end
        check("sweep.no_errs", {30'd0, err_overflow, err_orphan}, 32'd0);

        // Fill, overflow, in-order drain
        for (int i = 0; i < 5; i++) begin
            check($sformatf("fill%0d.not_full", i), {31'd0, req_track_full}, 32'd0);
            push(8'(i), 4'b1111, 7'h00);
        end
        check("fill.full", {31'd0, req_track_full}, 32'd1);
        check("fill.cnt",  {28'd0, outstanding_cnt}, 32'd5);
        push(8'h99, 4'b1111, 7'h00);
        check("ovf.flag", {31'd0, err_overflow}, 32'd1);
        check("ovf.cnt",  {28'd0, outstanding_cnt}, 32'd5);
        cpl_ready = 1'b1;
        axi_cpld_valid = 1'b1;
        axi_cpld_data  = 32'd0;
        #1;
        check("drain.full_gated_by_pop", {31'd0, req_track_full}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            axi_cpld_data = 32'(i) + 32'h100;
            tick();
            check($sformatf("drain%0d.valid", i), {31'd0, cpl_valid}, 32'd1);
            check($sformatf("drain%0d.tag", i),   {24'd0, cpl_tag}, 32'(i));
            check($sformatf("drain%0d.data", i),  cpl_data, 32'(i) + 32'h100);
        end
        axi_cpld_valid = 1'b0;
        tick();
        check("drain.cnt",   {28'd0, outstanding_cnt}, 32'd0);
        check("drain.idle",  {31'd0, cpl_valid}, 32'd0);
        cpl_ready = 1'b0;

        // Backpressure from the formatter
        push(8'hA0, 4'b0001, 7'h10);
        push(8'hA1, 4'b0010, 7'h20);
        beat(32'h1111_1111);
        axi_cpld_valid = 1'b1;
        axi_cpld_data  = 32'h2222_2222;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("bp%0d.ready_low", i), {31'd0, axi_cpld_ready}, 32'd0);
            check($sformatf("bp%0d.valid", i),     {31'd0, cpl_valid}, 32'd1);
            check($sformatf("bp%0d.stable", i),    {cpl_tag, 17'd0, cpl_lower_addr}, {8'hA0, 17'd0, 7'h10});
            check($sformatf("bp%0d.data", i),      cpl_data, 32'h1111_1111);
            tick();
        end
        cpl_ready = 1'b1;
        #1;
        check("bp.ready_release", {31'd0, axi_cpld_ready}, 32'd1);
        tick();
        axi_cpld_valid = 1'b0;
        check("bp.next_tag",  {24'd0, cpl_tag}, 32'hA1);
        check("bp.next_data", cpl_data, 32'h2222_2222);
        check("bp.next_laddr", {25'd0, cpl_lower_addr}, 32'h21);
        check("bp.next_valid", {31'd0, cpl_valid}, 32'd1);
        tick();
        check("bp.idle", {31'd0, cpl_valid}, 32'd0);
        cpl_ready = 1'b0;

        // Full FIFO with simultaneous push and pop; pointers wrap repeatedly
        do_reset();
        for (int i = 0; i < 5; i++) push(8'h20 + 8'(i), 4'b1111, 7'h00);
        cpl_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            set_req(8'h25 + 8'(i), 4'b1111, 7'h00);
            axi_cpld_valid = 1'b1;
            axi_cpld_data  = 32'hC000_0000 + 32'(i);
            tick();
            check($sformatf("wrap%0d.cnt", i), {28'd0, outstanding_cnt}, 32'd5);
            check($sformatf("wrap%0d.tag", i), {24'd0, cpl_tag}, {24'd0, 8'h20 + 8'(i)});
        end
        req_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            axi_cpld_data = 32'hD000_0000 + 32'(i);
            tick();
            check($sformatf("wdrain%0d.tag", i), {24'd0, cpl_tag}, {24'd0, 8'h2C + 8'(i)});
            check($sformatf("wdrain%0d.data", i), cpl_data, 32'hD000_0000 + 32'(i));
        end
        axi_cpld_valid = 1'b0;
        tick();
        check("wrap.cnt_end", {28'd0, outstanding_cnt}, 32'd0);
        check("wrap.no_ovf",  {31'd0, err_overflow}, 32'd0);
        cpl_ready = 1'b0;

        // Orphan beats, then reset mid-stream
        do_reset();
        #1;
        check("orph.ready", {31'd0, axi_cpld_ready}, 32'd1);
        beat(32'hBAD0_0001);
        check("orph.flag",  {31'd0, err_orphan}, 32'd1);
        check("orph.novld", {31'd0, cpl_valid}, 32'd0);
        tick();
        check("orph.novld2", {31'd0, cpl_valid}, 32'd0);
        set_req(8'h55, 4'b1111, 7'h00);
        axi_cpld_valid = 1'b1;
        axi_cpld_data  = 32'hBAD0_0002;
        tick();
        req_valid = 1'b0;
        axi_cpld_valid = 1'b0;
        check("orph_same.novld", {31'd0, cpl_valid}, 32'd0);
        check("orph_same.cnt",   {28'd0, outstanding_cnt}, 32'd1);
        push(8'h56, 4'b1111, 7'h00);
        beat(32'h600D_0001);
        check("orph_same.tag", {24'd0, cpl_tag}, 32'h55);
        check("mid.cnt",       {28'd0, outstanding_cnt}, 32'd1);
        rst = 1'b1;
        #1;
        check_reset_state("midrst");
        tick();
        rst = 1'b0;
        tick();
        check_reset_state("postrst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
